// File: rtl/stream_mux.sv
// Registered N-to-1 stream multiplexer. The channel is chosen either by a fixed
// select or by a round-robin arbiter, and the result feeds a one-deep output register.
module stream_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_ch
);

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            if (int'(sel) < CHANNELS) begin
                if (in_valid[sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = sel;
                end
            end
        end else begin
            // Scan from farthest to nearest so the candidate closest after ptr wins.
            for (int i = CHANNELS; i >= 1; i--) begin
                if (in_valid[(int'(ptr) + i) % CHANNELS]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'((int'(ptr) + i) % CHANNELS);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load_en && grant_vld && !rst) in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_ch    <= grant_idx;
                if (mode) ptr <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data width per channel in bits (>=1).
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (>=2).
REQ-003 The block SHALL use a derived local SEL_W, equal to ceil(log2(CHANNELS)), with a minimum of 1.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = fixed select via sel; 1 = round-robin arbitration.
REQ-008 The block SHALL have port sel, input, SEL_W bits: channel index used when mode=0.
REQ-009 The block SHALL have port in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_valid, input, CHANNELS bits: per-channel data valid.
REQ-011 The block SHALL have port in_ready, output, CHANNELS bits: per-channel accept, combinational.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-013 The block SHALL have port out_valid, output, 1 bit: registered output valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-015 The block SHALL have port out_ch, output, SEL_W bits: registered index of the channel that sourced out_data.

Function
REQ-016 A transfer on any port SHALL occur only in a cycle where the port's valid and ready are both 1 at the rising edge of clk.
REQ-017 The output register SHALL load when load_en = (!out_valid || out_ready) and a grant exists; this gives 1-cycle latency and a throughput of 1 word per cycle.
REQ-018 When load_en=1 and no grant exists, out_valid SHALL go to 0; out_data and out_ch SHALL hold their values.
REQ-019 When load_en=0 (out_valid=1 and out_ready=0), out_data, out_ch and out_valid SHALL hold stable.
REQ-020 In mode=0, the grant SHALL be channel sel when sel<CHANNELS and in_valid[sel]=1; otherwise there SHALL be no grant.
REQ-021 In mode=0, no in_ready bit SHALL assert when sel>=CHANNELS.
REQ-022 In mode=1, the grant SHALL be the first channel with in_valid=1, searching from ptr+1 upward and wrapping modulo CHANNELS back to ptr.
REQ-023 The ptr register (SEL_W bits) SHALL update to the granted index only on an accepted input transfer in mode=1; ptr SHALL be unchanged in mode=0.
REQ-024 in_ready[i] SHALL be 1 only when load_en=1 and channel i is granted; at most one in_ready bit SHALL be high in any cycle.
REQ-025 in_ready SHALL NOT depend combinationally on the in_valid of the non-granted channels beyond the grant computation; in_ready SHALL have no combinational path from out_data.
REQ-026 A mode or sel change SHALL affect only arbitration in the same cycle and SHALL NOT alter a word already held in the output register.
REQ-027 A single valid requester in mode=1 SHALL be granted on every cycle in which load_en=1; no idle bubble is permitted.

Reset
REQ-028 When rst=1 at a clk edge, the block SHALL set out_valid=0, out_data=0, out_ch=0 and ptr=CHANNELS-1, so channel 0 has first priority after reset.
REQ-029 While rst=1, in_ready SHALL be all zeros.
REQ-030 A reset asserted mid-operation SHALL discard any held output word without a downstream transfer.

Verification
REQ-031 The bench SHALL cover fixed select: WIDTH=4, CHANNELS=4, mode=0, sel=1, in_data={4'h4,4'h4,4'h1,4'h4}, all valid, out_ready=1 -> next cycle out_data=4'h1, out_ch=1, out_valid=1, in_ready=4'b0010.
REQ-032 The bench SHALL cover backpressure: a word held with out_ready=0 for 3 cycles while sel and in_data change -> out_data, out_ch and out_valid stay constant and in_ready=0; the word is delivered once when out_ready=1.
REQ-033 The bench SHALL cover round-robin: mode=1, in_valid=4'b1111, out_ready=1, held 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
REQ-034 The bench SHALL cover sparse round-robin: mode=1, in_valid=4'b1010 -> out_ch alternates 1,3,1,3; switching to in_valid=4'b0010 -> out_ch=1 on every cycle with no gap.
REQ-035 The bench SHALL cover out-of-range select and idle: with CHANNELS=3, mode=0, sel=3 -> in_ready=0, and out_valid falls to 0 after the held word drains.
REQ-036 The bench SHALL cover reset mid-stream: rst=1 for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_ch=0 next cycle, and the first round-robin grant afterwards is channel 0.
